gpio_out_tx: RTL and testbench
==============================

// Module: gpio_out_tx
// PURPOSE
//  Transmit side of the GPIO byte interface. Buffers bytes pushed by the core/register
//  file and drives them onto out_GPIO with a paced out_GPIO_valid strobe.
//  Setup and hold time around each strobe is programmable by parameter. Sending is
//  gated by an external, asynchronous ready line. Sits between the RF and the pads.
// PARAMETERS
//  DEPTH       4  FIFO entries; power of 2, >=2
//  SETUP_CYC   1  cycles data is stable before valid rises; >=1
//  STROBE_CYC  2  cycles valid stays high; >=1
//  HOLD_CYC    1  cycles data is held after valid falls; >=1
// PORTS
//  i_clk              in   1            system clock, all logic on posedge
//  i_rstn             in   1            async active-low reset
//  wr_data            in   8            byte from RF
//  wr_valid           in   1            push request
//  wr_ready           out  1            FIFO not full
//  clr_overflow       in   1            clears overflow flag
//  overflow           out  1            sticky: push attempted while full
//  fifo_level         out  $clog2(DEPTH)+1  entries held
//  ext_ready_async    in   1            receiver ready, asynchronous to i_clk
//  out_GPIO           out  8            byte to pads
//  out_GPIO_valid     out  1            strobe to pads
//  tx_busy            out  1            FSM not in IDLE
// BEHAVIOUR
//  Reset: i_clk single clock; i_rstn asynchronous, active-low. Assertion at any time,
//   including mid-transfer, immediately forces every output and register to 0:
//   out_GPIO=0, out_GPIO_valid=0, tx_busy=0, overflow=0, fifo_level=0, sync flops=0,
//   FSM=IDLE. After reset, wr_ready=1 (FIFO empty).
//  Push: accepted when wr_valid && wr_ready. wr_ready = !full, based on current level.
//   A push while full is rejected even if a pop happens in the same cycle.
//   Simultaneous push and pop leaves the level unchanged.
//  Overflow: wr_valid && !wr_ready sets overflow on the next edge.
//   clr_overflow clears it. If set and clear occur in the same cycle, set wins.
//  ext_ready_async: 2-flop synchroniser gives rdy_s. Adds 2 cycles of latency.
//  FSM states: IDLE, SETUP, STROBE, HOLD. A down-counter cnt sets each phase length.
//   IDLE:   if !empty && rdy_s: load out_GPIO<=head, pop, cnt<=SETUP_CYC-1 -> SETUP.
//           Otherwise stay. out_GPIO keeps its last value, valid=0.
//   SETUP:  valid=0; at cnt==0: cnt<=STROBE_CYC-1 -> STROBE; else cnt--.
//   STROBE: valid=1 (registered); at cnt==0: cnt<=HOLD_CYC-1 -> HOLD; else cnt--.
//   HOLD:   valid=0, data held; at cnt==0 -> IDLE; else cnt--.
//  rdy_s is sampled only in IDLE. Deassertion mid-transfer does not abort the byte.
//  Minimum byte period is SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles, because IDLE
//   lasts at least 1 cycle.
//  Latency: push accepted at edge E. The FIFO is non-empty after E. The load happens
//   at E+1, so out_GPIO changes at E+1. valid rises at E+1+SETUP_CYC (with rdy_s=1).
//  Bytes leave in push order. No byte is dropped or duplicated. Wrap-around uses
//   log2(DEPTH)+1-bit pointers; full/empty come from MSB compare.
//  out_GPIO and out_GPIO_valid come straight from flops (glitch-free at the pads).
// STRUCTURE
//  gpio_pkg: typedef enum logic [1:0] {IDLE,SETUP,STROBE,HOLD} gpio_tx_state_t;
//   localparam GPIO_W = 8.
//  Sub-module gpio_tx_fifo: sync FIFO, DEPTH x GPIO_W, with push/pop/full/empty/level.
//   Top level holds the synchroniser, FSM, counter, output regs and overflow flag.
// TESTING
//  1. Reset, then push 0xA5 with ext_ready=1 (defaults) -> out_GPIO=0xA5 at E+1.
//     valid is high for exactly 2 cycles starting at E+2. tx_busy is 0 again after HOLD.
//  2. ext_ready=0, push 0x01..0x04 -> wr_ready=0 and fifo_level=4, no strobe.
//     Push 0x05 -> overflow=1. Raise ready -> 4 strobes carry 0x01..0x04 in order.
//  3. Full FIFO with a pop and a push in the same cycle -> push rejected, overflow=1,
//     level=3. clr_overflow together with a rejected push -> overflow stays 1.
//  4. Drop ext_ready during STROBE -> current byte completes its HOLD.
//     The next byte waits until rdy_s=1.
//  5. Assert i_rstn=0 mid-STROBE -> valid=0 and out_GPIO=0 immediately (async).
//     FIFO is empty after release.
//  6. SETUP_CYC=3, HOLD_CYC=2, STROBE_CYC=1: back-to-back bytes -> period is 7 cycles,
//     and data is stable from 3 cycles before valid through 2 cycles after it.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared types and constants for the GPIO byte transmit path.
package gpio_pkg;

  localparam int GPIO_W = 8;

  // state | meaning
  // IDLE   | waiting for a buffered byte and a synchronised receiver-ready
  // SETUP  | byte on the pads, strobe low, data settling
  // STROBE | strobe high, receiver latches the byte
  // HOLD   | strobe low again, byte kept on the pads
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } gpio_tx_state_t;

  // Largest phase length, used to size the shared phase down-counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gpio_tx_fifo.sv
// Synchronous byte FIFO. Pointers carry one extra wrap bit so full and empty
// are told apart by comparing the MSBs. Pushes while full and pops while empty
// are ignored here, so callers may drive raw requests.
module gpio_tx_fifo
  import gpio_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = GPIO_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         push_ok;
  logic         pop_ok;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Fullness is judged on the current level: a pop in the same cycle does not
  // make room for a push.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer advance.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; cleared on reset so nothing stale can reach the pads.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/gpio_out_tx.sv
// GPIO byte transmitter: buffers bytes from the register file and paces them
// onto the pads with a setup / strobe / hold sequence, gated by a receiver
// ready line that is asynchronous to i_clk.
//
// state  | meaning
// IDLE   | wait for a buffered byte with rdy_s high; load it and pop
// SETUP  | data on pads, valid low, SETUP_CYC cycles
// STROBE | valid high, STROBE_CYC cycles
// HOLD   | valid low, data held, HOLD_CYC cycles
module gpio_out_tx
  import gpio_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic [7:0]                wr_data,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic                      clr_overflow,
  output logic                      overflow,
  output logic [$clog2(DEPTH):0]    fifo_level,
  input  logic                      ext_ready_async,
  output logic [7:0]                out_GPIO,
  output logic                      out_GPIO_valid,
  output logic                      tx_busy
);

  localparam int CNT_MAX = max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYC - 1);

  gpio_tx_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GPIO_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              overflow_q, overflow_d;
  logic              sync1_q, sync2_q;
  logic              rdy_s;

  logic [GPIO_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              push_req;

  assign wr_ready = !fifo_full;
  assign push_req = wr_valid && !fifo_full;

  gpio_tx_fifo #(
    .DEPTH (DEPTH),
    .W     (GPIO_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .push_i  (push_req),
    .data_i  (wr_data),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Two-flop synchroniser for the receiver ready line.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= ext_ready_async;
      sync2_q <= sync1_q;
    end
  end

  assign rdy_s = sync2_q;

  // Sticky overflow: a rejected push outranks a clear in the same cycle.
  always_comb begin
    overflow_d = overflow_q;
    if (wr_valid && fifo_full) overflow_d = 1'b1;
    else if (clr_overflow)     overflow_d = 1'b0;
  end

  // Next state, phase counter and data load. rdy_s only matters in IDLE, so a
  // byte already started always runs through HOLD.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && rdy_s) begin
          data_d   = fifo_head;
          fifo_pop = 1'b1;
          cnt_d    = SETUP_LOAD;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = STROBE_LOAD;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          cnt_d   = HOLD_LOAD;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobe is a flop that tracks the next state, so it is high exactly while
  // the FSM sits in STROBE and reaches the pads without decode glitches.
  assign valid_d = (state_d == STROBE);

  // FSM, counter, output and flag registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_GPIO       = data_q;
  assign out_GPIO_valid = valid_q;
  assign overflow       = overflow_q;
  assign tx_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_gpio_out_tx.sv
// Directed bench for gpio_out_tx: default timing instance plus a second
// instance with a long setup and hold for the back-to-back period check.
module tb_gpio_out_tx;

  logic       clk = 1'b0;
  logic       rst_n;

  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       clr_ovf;
  logic       ovf;
  logic [2:0] level;
  logic       ext_rdy;
  logic [7:0] gpio;
  logic       gpio_valid;
  logic       busy;

  logic [7:0] wr_data6;
  logic       wr_valid6;
  logic       wr_ready6;
  logic       clr_ovf6;
  logic       ovf6;
  logic [2:0] level6;
  logic       ext_rdy6;
  logic [7:0] gpio6;
  logic       gpio_valid6;
  logic       busy6;

  int checks = 0;
  int errors = 0;

  logic [7:0] strobes[$];
  logic       vld_prev = 1'b0;

  always #5 clk = ~clk;

  gpio_out_tx u_dut (
    .i_clk           (clk),
    .i_rstn          (rst_n),
    .wr_data         (wr_data),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .clr_overflow    (clr_ovf),
    .overflow        (ovf),
    .fifo_level      (level),
    .ext_ready_async (ext_rdy),
    .out_GPIO        (gpio),
    .out_GPIO_valid  (gpio_valid),
    .tx_busy         (busy)
  );

  gpio_out_tx #(
    .DEPTH      (4),
    .SETUP_CYC  (3),
    .STROBE_CYC (1),
    .HOLD_CYC   (2)
  ) u_dut6 (
    .i_clk           (clk),
    .i_rstn          (rst_n),
    .wr_data         (wr_data6),
    .wr_valid        (wr_valid6),
    .wr_ready        (wr_ready6),
    .clr_overflow    (clr_ovf6),
    .overflow        (ovf6),
    .fifo_level      (level6),
    .ext_ready_async (ext_rdy6),
    .out_GPIO        (gpio6),
    .out_GPIO_valid  (gpio_valid6),
    .tx_busy         (busy6)
  );

  // Record the byte on the pads at every rising strobe of the default instance.
  always @(negedge clk) begin
    if (gpio_valid && !vld_prev) strobes.push_back(gpio);
    vld_prev = gpio_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    wr_data  = d;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!gpio_valid && n < 50) begin
      tick();
      n++;
    end
    chk(tag, gpio_valid, 1);
  endtask

  task automatic wait_strobes(input string tag, input int cnt);
    int n = 0;
    while (strobes.size() < cnt && n < 100) begin
      tick();
      n++;
    end
    chk(tag, strobes.size(), cnt);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || level != 0) && n < 100) begin
      tick();
      n++;
    end
    chk(tag, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_b [4];
    rst_n     = 1'b1;
    wr_data   = '0;
    wr_valid  = 1'b0;
    clr_ovf   = 1'b0;
    ext_rdy   = 1'b1;
    wr_data6  = '0;
    wr_valid6 = 1'b0;
    clr_ovf6  = 1'b0;
    ext_rdy6  = 1'b1;

    // Reset values.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out",   gpio, 0);
    chk("rst_valid", gpio_valid, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_ovf",   ovf, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", wr_ready, 1);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // 1: single byte, default timing.
    push(8'hA5);
    chk("t1_level_e",  level, 1);
    chk("t1_out_e",    gpio, 0);
    tick();
    chk("t1_out_e1",   gpio, 8'hA5);
    chk("t1_valid_e1", gpio_valid, 0);
    chk("t1_busy_e1",  busy, 1);
    tick();
    chk("t1_valid_e2", gpio_valid, 1);
    tick();
    chk("t1_valid_e3", gpio_valid, 1);
    tick();
    chk("t1_valid_e4", gpio_valid, 0);
    chk("t1_busy_e4",  busy, 1);
    chk("t1_out_e4",   gpio, 8'hA5);
    tick();
    chk("t1_busy_e5",  busy, 0);
    chk("t1_out_e5",   gpio, 8'hA5);

    // 2: fill while receiver not ready, overflow, then drain in order.
    ext_rdy = 1'b0;
    repeat (3) tick();
    strobes.delete();
    for (int i = 1; i <= 4; i++) push(8'(i));
    chk("t2_ready",  wr_ready, 0);
    chk("t2_level",  level, 4);
    push(8'h05);
    chk("t2_ovf",    ovf, 1);
    chk("t2_level5", level, 4);
    repeat (5) tick();
    chk("t2_nostrobe", strobes.size(), 0);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t2_ovf_clr", ovf, 0);
    ext_rdy = 1'b1;
    wait_strobes("t2_count", 4);
    for (int i = 0; i < 4; i++)
      if (i < strobes.size()) chk($sformatf("t2_byte%0d", i), strobes[i], i + 1);
    wait_idle("t2_idle");

    // 3: set-wins overflow, and push rejected while full even with a pop.
    ext_rdy = 1'b0;
    repeat (3) tick();
    strobes.delete();
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    chk("t3_level4", level, 4);
    wr_data  = 8'h99;
    wr_valid = 1'b1;
    clr_ovf  = 1'b1;
    tick();
    wr_valid = 1'b0;
    clr_ovf  = 1'b0;
    chk("t3_set_wins", ovf, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t3_ovf_clr", ovf, 0);
    wr_data  = 8'h55;
    wr_valid = 1'b1;
    ext_rdy  = 1'b1;
    tick();
    tick();
    tick();
    wr_valid = 1'b0;
    chk("t3_level3", level, 3);
    chk("t3_ovf",    ovf, 1);
    chk("t3_busy",   busy, 1);
    wait_idle("t3_idle");
    repeat (6) tick();
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    chk("t3_count", strobes.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < strobes.size()) chk($sformatf("t3_byte%0d", i), strobes[i], exp_b[i]);

    // 4: receiver drops ready mid-strobe; current byte finishes, next waits.
    strobes.delete();
    push(8'h66);
    push(8'h77);
    wait_valid("t4_strobe");
    ext_rdy = 1'b0;
    begin
      int n = 0;
      while (gpio_valid && n < 20) begin
        tick();
        n++;
      end
    end
    chk("t4_hold_busy", busy, 1);
    chk("t4_hold_data", gpio, 8'h66);
    repeat (10) tick();
    chk("t4_one_sent", strobes.size(), 1);
    chk("t4_waiting",  level, 1);
    chk("t4_idle",     busy, 0);
    ext_rdy = 1'b1;
    wait_strobes("t4_count", 2);
    if (strobes.size() >= 2) chk("t4_second", strobes[1], 8'h77);
    wait_idle("t4_done");

    // 5: async reset mid-strobe.
    push(8'h3C);
    push(8'h4D);
    wait_valid("t5_strobe");
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid", gpio_valid, 0);
    chk("t5_out",   gpio, 0);
    chk("t5_busy",  busy, 0);
    chk("t5_level", level, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("t5_level_rel", level, 0);
    chk("t5_ready_rel", wr_ready, 1);

    // 6: SETUP=3 STROBE=1 HOLD=2, two bytes back to back.
    wr_data6  = 8'hC1;
    wr_valid6 = 1'b1;
    tick();
    wr_data6  = 8'hC2;
    tick();
    wr_valid6 = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      logic [8:0] exp6;
      if (i > 1) tick();
      exp6 = {(i == 4 || i == 11), ((i <= 7) ? 8'hC1 : 8'hC2)};
      chk($sformatf("t6_cyc%0d", i), {gpio_valid6, gpio6}, exp6);
    end
    repeat (3) tick();
    chk("t6_idle", busy6, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
